// File: rtl/ct_spsram_256x196_acc_ctrl.sv
// Requester for the 256x196 single-port SRAM: valid/ready requests become same-cycle active-low pin cycles; read data returns 2 cycles after accept via a 2-entry FIFO.
// Reads are credit-limited by the FIFO (writes never stall on rsp_rdy); CT_SPSRAM_ACC_INIT_EN adds a 256-cycle zero-fill after reset.
module ct_spsram_256x196_acc_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 196,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [2:0] RSP_CREDITS = 3'(RSP_DEPTH);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_addr;
    logic                    rd_inflight;
    logic [1:0]              fifo_cnt;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [DATA_WIDTH-1:0]   rsp_mem [RSP_DEPTH];
    logic                    push;
    logic                    pop;
    logic                    rd_credit;
    logic                    rd_accept;

`ifdef CT_SPSRAM_ACC_INIT_EN
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   init_cnt;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == {ADDR_WIDTH{1'b1}}) begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign init_addr = init_cnt;
`else
    assign state     = ST_RUN;
    assign init_addr = '0;
`endif

    assign init_done = (state == ST_RUN);
    assign rsp_vld   = (fifo_cnt != 2'd0);
    assign rsp_rdata = rsp_mem[rd_ptr];
    assign push      = rd_inflight;
    assign pop       = rsp_vld & rsp_rdy;

    // A same-cycle pop frees a slot, which is what lets reads stream at one per cycle.
    assign rd_credit = (({1'b0, fifo_cnt} + {2'b0, rd_inflight} - {2'b0, pop}) < RSP_CREDITS);

    // Output process: pins are forced idle while reset is low so nothing reaches the array.
    always_comb begin
        req_rdy   = 1'b0;
        rd_accept = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (cpurst_b) begin
            if (state == ST_INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = init_addr;
            end else begin
                req_rdy = req_wr | rd_credit;
                if (req_vld && req_rdy) begin
                    sram_cen = 1'b0;
                    sram_a   = req_addr;
                    if (req_wr) begin
                        sram_gwen = 1'b0;
                        sram_wen  = ~req_wmask;
                        sram_d    = req_wdata;
                    end else begin
                        rd_accept = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_inflight <= 1'b0;
            fifo_cnt    <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
        end else begin
            rd_inflight <= rd_accept;
            fifo_cnt    <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            wr_ptr      <= wr_ptr ^ push;
            rd_ptr      <= rd_ptr ^ pop;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (push) begin
            rsp_mem[wr_ptr] <= sram_q;
        end
    end

endmodule

// File: tb/tb_ct_spsram_256x196_acc_ctrl.sv
// Directed bench with a behavioural SRAM and a queue scoreboard; monitor pops on every rsp handshake.
module tb_ct_spsram_256x196_acc_ctrl;
    localparam int DW = 196;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_vld, req_rdy, req_wr;
    logic [7:0]    req_addr;
    logic [DW-1:0] req_wdata, req_wmask;
    logic          rsp_vld, rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;
    logic [7:0]    sram_a;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [DW-1:0] exp_q [$];
    int            rsp_cyc [$];
    logic [DW-1:0] mon_exp;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] pin_wen;
    logic [7:0]    pin_a;
    logic          pin_gwen;
    int            dw, da, first_acc, stall, errs, w, a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ct_spsram_256x196_acc_ctrl dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        return (DW'(k) << 100) | DW'(k * 7 + 1);
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected act=%h exp=none", rsp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rsp_data", rsp_rdata, mon_exp);
                rsp_cyc.push_back(cyc);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] wm, input logic [DW-1:0] exp,
                          output int waited, output int acc);
        int n;
        n = 0;
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_wmask = wm;
        @(negedge clk);
        while (req_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        acc = cyc;
        if (req_rdy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL req_timeout act=rdy0 exp=rdy1 addr=%h", addr);
        end else begin
            pin_wen = sram_wen; pin_a = sram_a; pin_gwen = sram_gwen;
            if (!wr) exp_q.push_back(exp);
        end
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic wr_req(input logic [7:0] addr, input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        do_req(1'b1, addr, wd, wm, '0, dw, da);
    endtask

    task automatic rd_req(input logic [7:0] addr, input logic [DW-1:0] exp);
        do_req(1'b0, addr, '0, '0, exp, dw, da);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        req_vld = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; rsp_rdy = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_vld", DW'(rsp_vld), '0);
        chk("rst_req_rdy", DW'(req_rdy), '0);
        chk("rst_cen", DW'(sram_cen), DW'(1));
        chk("rst_gwen", DW'(sram_gwen), DW'(1));
        chk("rst_wen", sram_wen, '1);
        chk("rst_a_d", DW'(sram_a) | sram_d, '0);
`ifdef CT_SPSRAM_ACC_INIT_EN
        chk("rst_init_done", DW'(init_done), '0);
`else
        chk("rst_init_done", DW'(init_done), DW'(1));
`endif
        rst_n = 1'b1;

`ifdef CT_SPSRAM_ACC_INIT_EN
        req_wr = 1'b1;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (init_done !== 1'b0 || req_rdy !== 1'b0 || sram_cen !== 1'b0 ||
                sram_gwen !== 1'b0 || sram_wen !== '0 || sram_a !== 8'(i)) errs++;
        end
        chk("init_sweep_errs", DW'(errs), '0);
        @(negedge clk);
        chk("init_done_after_fill", DW'(init_done), DW'(1));
        req_wr = 1'b0;
        @(posedge clk); #1;
        rd_req(8'h80, '0);
        repeat (4) @(posedge clk);
        #1;
`else
        @(negedge clk);
        chk("init_done_tied", DW'(init_done), DW'(1));
        @(posedge clk); #1;
`endif

        // write then immediate read of the same address, latency 2
        wr_req(8'h10, DW'({25{8'hA5}}), '1);
        chk("wr_pins_gwen_a", {DW'(pin_gwen), DW'(pin_a)}, {DW'(0), DW'(8'h10)});
        rd_req(8'h10, DW'({25{8'hA5}}));
        @(negedge clk);
        chk("lat_t1_rsp_vld", DW'(rsp_vld), '0);
        @(negedge clk);
        chk("lat_t2_rsp_vld", DW'(rsp_vld), DW'(1));
        @(posedge clk); #1;

        // partial bit mask
        wr_req(8'h03, '1, '1);
        wr_req(8'h03, '0, DW'(8'hFF));
        chk("pm_wen", pin_wen, ~DW'(8'hFF));
        rd_req(8'h03, {{188{1'b1}}, 8'h00});
        repeat (4) @(posedge clk);
        #1;

        // backpressure: only two reads fit while rsp_rdy is low
        for (int k = 1; k <= 4; k++) wr_req(8'(k), pat(k), '1);
        rsp_rdy = 1'b0;
        rd_req(8'h01, pat(1));
        rd_req(8'h02, pat(2));
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h03;
        @(negedge clk);
        chk("bp_rd_blocked", DW'(req_rdy), '0);
        req_wr = 1'b1; req_addr = 8'h50; req_wdata = pat(9); req_wmask = '1;
        #1;
        chk("bp_wr_accepted", DW'({req_rdy, sram_gwen}), DW'(2'b10));
        @(posedge clk); #1;
        req_wr = 1'b0; req_addr = 8'h04;
        errs = 0;
        repeat (3) begin
            @(negedge clk);
            if (req_rdy !== 1'b0) errs++;
        end
        chk("bp_hold_blocked", DW'(errs), '0);
        @(posedge clk); #1;
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        rd_req(8'h03, pat(3));
        rd_req(8'h04, pat(4));
        rd_req(8'h50, pat(9));
        repeat (4) @(negedge clk);
        chk("bp_drained", DW'(exp_q.size()), '0);
        @(posedge clk); #1;

        // streaming 8 reads
        for (int k = 0; k < 8; k++) wr_req(8'(8'h20 + k), pat(32 + k), '1);
        rsp_cyc.delete();
        stall = 0;
        for (int k = 0; k < 8; k++) begin
            do_req(1'b0, 8'(8'h20 + k), '0, '0, pat(32 + k), w, a);
            if (k == 0) first_acc = a;
            stall += w;
        end
        repeat (4) @(negedge clk);
        chk("stream_rdy_stalls", DW'(stall), '0);
        chk("stream_rsp_count", DW'(rsp_cyc.size()), DW'(8));
        errs = 0;
        for (int k = 0; k < rsp_cyc.size(); k++) if (rsp_cyc[k] != first_acc + 2 + k) errs++;
        chk("stream_rsp_cycles", DW'(errs), '0);
        @(posedge clk); #1;

        // reset with one read in flight and one in the FIFO
        rsp_rdy = 1'b0;
        rd_req(8'h20, pat(32));
        rd_req(8'h21, pat(33));
        chk("mr_pre_rsp_vld", DW'(rsp_vld), DW'(1));
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 8'h60; req_wdata = pat(5); req_wmask = '1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mr_rsp_vld", DW'(rsp_vld), '0);
        chk("mr_cen", DW'(sram_cen), DW'(1));
        req_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_rdy = 1'b1;
`ifdef CT_SPSRAM_ACC_INIT_EN
        @(negedge clk);
        chk("mr_fill_restart", DW'({sram_gwen, sram_a}), '0);
        errs = 0;
        while (init_done !== 1'b1 && errs < 400) begin
            @(negedge clk);
            errs++;
        end
        chk("mr_init_done", DW'(init_done), DW'(1));
`endif
        errs = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_vld !== 1'b0) errs++;
        end
        chk("mr_no_stale", DW'(errs), '0);
        chk("final_queue_empty", DW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
